// File: rtl/instruction_encoder.sv
// instruction_encoder: assembles RV32I instruction words from decoded field
// bundles and queues them in an in-order output FIFO.
// Optional build macro INSTR_ENCODER_STATS_EN enables the encoded/illegal
// statistics counters; without it both counter ports read as zero.
module instruction_encoder #(
  parameter int CORE       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_class,
  input  logic [2:0]                    in_funct3,
  input  logic [6:0]                    in_funct7,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [31:0]                   in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instruction,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err_illegal,
  output logic [31:0]                   encoded_count,
  output logic [15:0]                   illegal_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_encoder: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CORE < 0) begin : g_bad_core
    $error("instruction_encoder: CORE index must be non-negative");
  end

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        err_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        push;
  logic        pop;

  assign count           = wr_ptr_q - rd_ptr_q;
  assign in_ready        = (count != FULL_COUNT);
  assign out_valid       = (count != '0);
  assign out_instruction = mem_q[rd_ptr_q[AW-1:0]];
  assign err_illegal     = err_q;

  assign accept = in_valid && in_ready;
  // Flush wins over data movement; an illegal bundle is accepted but never written.
  assign push   = accept && enc_legal && !flush;
  assign pop    = out_valid && out_ready && !flush;

  // Field packing per instruction class; classes 11-15 are flagged illegal.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_class)
      4'd0:  enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd1: begin
        // Shift-immediates carry funct7 in the upper bits and shamt in imm[4:0].
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      4'd2:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd3:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd4:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], 7'b1100011};
      4'd5:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      4'd6:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, 7'b1101111};
      4'd7:  enc_word = {in_imm[31:12], in_rd, 7'b0010111};
      4'd8:  enc_word = {in_imm[31:12], in_rd, 7'b0110111};
      4'd9:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0001111};
      4'd10: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1110011};
      default: enc_legal = 1'b0;
    endcase
  end

  // Next-state pointers: flush empties the queue, otherwise advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer and illegal-pulse registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= accept && !enc_legal;
    end
  end

  // Storage array write at the tail; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_ptr_q[AW-1:0]] <= enc_word;
  end

`ifdef INSTR_ENCODER_STATS_EN
  logic [31:0] encoded_count_q;
  logic [15:0] illegal_count_q;

  // Statistics count every accept (flush does not clear them); illegal count saturates.
  always_ff @(posedge clock) begin
    if (!reset) begin
      encoded_count_q <= '0;
      illegal_count_q <= '0;
    end else if (accept) begin
      if (enc_legal)
        encoded_count_q <= encoded_count_q + 32'd1;
      else if (illegal_count_q != 16'hFFFF)
        illegal_count_q <= illegal_count_q + 16'd1;
    end
  end

  assign encoded_count = encoded_count_q;
  assign illegal_count = illegal_count_q;
`else
  assign encoded_count = '0;
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [2:0]  count;
  logic        err_illegal;
  logic [31:0] encoded_count;
  logic [15:0] illegal_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_legal = 0;

  instruction_encoder #(.CORE(0), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .count(count), .err_illegal(err_illegal),
    .encoded_count(encoded_count), .illegal_count(illegal_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef INSTR_ENCODER_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_fields(input logic [3:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    in_class = cls; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic push_one(input logic [3:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
    set_fields(cls, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_legal++;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(tag, out_instruction, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [31:0] addi_words [5];

  initial begin
    // addi xk, x0, k for k = 1..5
    addi_words[0] = 32'h00100093;
    addi_words[1] = 32'h00200113;
    addi_words[2] = 32'h00300193;
    addi_words[3] = 32'h00400213;
    addi_words[4] = 32'h00500293;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(4'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clock);
    step();
    step();
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_enc_cnt", encoded_count, 32'd0);
    chk("rst_ill_cnt", {16'd0, illegal_count}, 32'd0);
    reset = 1'b1;
    step();

    // R_TYPE add x3,x1,x2 with consumer ready: one-edge latency, then drains.
    set_fields(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    chk("r_no_bypass", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b0; n_legal++;
    chk("r_valid", {31'd0, out_valid}, 32'd1);
    chk("r_word", out_instruction, 32'h002081B3);
    step();
    out_ready = 1'b0;
    chk("r_drained", {31'd0, out_valid}, 32'd0);

    // Directed encodings.
    push_one(4'd8, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    expect_head("lui", 32'h123452B7);
    push_one(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    expect_head("branch", 32'hFE208EE3);
    push_one(4'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    expect_head("jal", 32'h0000006F);
    push_one(4'd2, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_head("store_sw", 32'h0020A423);
    push_one(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_head("addi_neg", 32'hFFF00093);
    push_one(4'd1, 3'd5, 7'b0100000, 5'd5, 5'd6, 5'd0, 32'd3);
    expect_head("srai", 32'h40335293);
    push_one(4'd5, 3'd7, 7'd0, 5'd1, 5'd5, 5'd0, 32'd4);
    expect_head("jalr_f3", 32'h004280E7);

    // Fill the FIFO with out_ready low, then a fifth bundle must stall.
    for (int k = 1; k <= 4; k++)
      push_one(4'd1, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
    set_fields(4'd1, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    step();
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", out_instruction, addi_words[0]);
    out_ready = 1'b1;
    step();
    chk("drain_count1", {29'd0, count}, 32'd3);
    chk("drain_head2", out_instruction, addi_words[1]);
    step();                      // pop word 2, fifth bundle pushed
    in_valid = 1'b0; n_legal++;
    chk("drain_count2", {29'd0, count}, 32'd3);
    for (int k = 2; k < 5; k++) begin
      chk($sformatf("drain_head%0d", k + 1), out_instruction, addi_words[k]);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", {29'd0, count}, 32'd0);

    // Illegal class: no write, single-cycle error pulse.
    push_one(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    set_fields(4'd15, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill_err_hi", {31'd0, err_illegal}, 32'd1);
    chk("ill_count", {29'd0, count}, 32'd1);
    chk("ill_stat", {16'd0, illegal_count}, stat_exp(32'd1));
    chk("ill_enc_stat", encoded_count, stat_exp(32'(n_legal)));
    step();
    chk("ill_err_lo", {31'd0, err_illegal}, 32'd0);
    expect_head("ill_head", addi_words[0]);

    // Reset with three words buffered.
    for (int k = 1; k <= 3; k++)
      push_one(4'd1, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_legal = 0;
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_enc", encoded_count, 32'd0);
    chk("mid_rst_ill", {16'd0, illegal_count}, 32'd0);

    // Flush with a simultaneous push drops everything including the new word.
    for (int k = 1; k <= 3; k++)
      push_one(4'd1, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
    chk("pre_fl_count", {29'd0, count}, 32'd3);
    set_fields(4'd8, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0; n_legal++;
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("flush_stays", {29'd0, count}, 32'd0);

    // Illegal accept during flush still pulses the error.
    set_fields(4'd12, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_ill_err", {31'd0, err_illegal}, 32'd1);
    chk("flush_ill_cnt", {29'd0, count}, 32'd0);
    chk("end_enc_stat", encoded_count, stat_exp(32'(n_legal)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
